// File: rtl/bit_serializer_pkg.sv
// Shared types and constants for the bit_serializer front end.
package ser_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  localparam int unsigned DEFAULT_WIDTH = 8;

  localparam bit MSB_FIRST_ORDER = 1'b1;
  localparam bit LSB_FIRST_ORDER = 1'b0;

endpackage

// File: rtl/bit_serializer_word_hold_reg.sv
// One-word pending buffer; a write in the same cycle as a read keeps it full.
module word_hold_reg
  import ser_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             full_q, full_d;

  always_comb begin
    data_d = data_q;
    full_d = full_q;
    if (rd_en) begin
      full_d = 1'b0;
    end
    if (wr_en) begin
      data_d = wr_data;
      full_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q <= '0;
      full_q <= 1'b0;
    end else begin
      data_q <= data_d;
      full_q <= full_d;
    end
  end

  assign rd_data = data_q;
  assign full    = full_q;

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial converter: valid/ready word input, one bit per clock out,
// with a one-word pending buffer so back-to-back words stream without gaps.
module bit_serializer
  import ser_pkg::*;
#(
  parameter int unsigned WIDTH     = DEFAULT_WIDTH,
  parameter bit          MSB_FIRST = MSB_FIRST_ORDER,
  parameter bit          IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             word_start,
  output logic             word_done,
  output logic             busy
);

  localparam int unsigned    CNT_W       = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(WIDTH - 1);
  localparam bit             SHIFT_RIGHT = (MSB_FIRST == LSB_FIRST_ORDER);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] shift_reg_q, shift_reg_d;

  logic             pend_full;
  logic             pend_wr_en;
  logic             pend_rd_en;
  logic [WIDTH-1:0] pend_data;

  logic transfer_c;
  logic last_bit_c;
  logic shifter_free_c;

  assign transfer_c     = in_valid && !pend_full;
  assign last_bit_c     = (state_q == SHIFT) && (cnt_q == LAST_CNT);
  assign shifter_free_c = (state_q == IDLE) || last_bit_c;

  word_hold_reg #(
    .WIDTH (WIDTH)
  ) u_hold (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (pend_wr_en),
    .wr_data (in_data),
    .rd_en   (pend_rd_en),
    .rd_data (pend_data),
    .full    (pend_full)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      shift_reg_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_reg_q <= shift_reg_d;
    end
  end

  // Next state: pending word has priority over a fresh input word when the shifter frees up
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_reg_d = shift_reg_q;
    pend_wr_en  = 1'b0;
    pend_rd_en  = 1'b0;
    if (shifter_free_c) begin
      if (pend_full) begin
        state_d     = SHIFT;
        cnt_d       = '0;
        shift_reg_d = pend_data;
        pend_rd_en  = 1'b1;
        pend_wr_en  = transfer_c;
      end else if (transfer_c) begin
        state_d     = SHIFT;
        cnt_d       = '0;
        shift_reg_d = in_data;
      end else begin
        state_d = IDLE;
      end
    end else begin
      pend_wr_en  = transfer_c;
      cnt_d       = cnt_q + CNT_W'(1);
      shift_reg_d = SHIFT_RIGHT ? {1'b0, shift_reg_q[WIDTH-1:1]}
                                : {shift_reg_q[WIDTH-2:0], 1'b0};
    end
  end

  // Outputs decoded from registered state only
  always_comb begin
    serial_out   = IDLE_BIT;
    serial_valid = 1'b0;
    word_start   = 1'b0;
    word_done    = 1'b0;
    if (state_q == SHIFT) begin
      serial_out   = SHIFT_RIGHT ? shift_reg_q[0] : shift_reg_q[WIDTH-1];
      serial_valid = 1'b1;
      word_start   = (cnt_q == '0);
      word_done    = last_bit_c;
    end
  end

  assign busy     = (state_q == SHIFT) || pend_full;
  assign in_ready = !pend_full;

endmodule

// File: tb/tb_bit_serializer.sv
// Self-checking bench for bit_serializer: MSB-first, LSB-first and WIDTH=2 instances.
module tb_bit_serializer;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] m_data, l_data;
  logic [1:0] n_data;
  logic m_valid, m_ready, m_so, m_sv, m_ws, m_wd, m_busy;
  logic l_valid, l_ready, l_so, l_sv, l_ws, l_wd, l_busy;
  logic n_valid, n_ready, n_so, n_sv, n_ws, n_wd, n_busy;

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_m (
    .clk(clk), .reset(reset), .in_data(m_data), .in_valid(m_valid), .in_ready(m_ready),
    .serial_out(m_so), .serial_valid(m_sv), .word_start(m_ws), .word_done(m_wd), .busy(m_busy));

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) dut_l (
    .clk(clk), .reset(reset), .in_data(l_data), .in_valid(l_valid), .in_ready(l_ready),
    .serial_out(l_so), .serial_valid(l_sv), .word_start(l_ws), .word_done(l_wd), .busy(l_busy));

  bit_serializer #(.WIDTH(2), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_n (
    .clk(clk), .reset(reset), .in_data(n_data), .in_valid(n_valid), .in_ready(n_ready),
    .serial_out(n_so), .serial_valid(n_sv), .word_start(n_ws), .word_done(n_wd), .busy(n_busy));

  task automatic test_reset;
    reset = 1'b1;
    m_valid = 1'b0; l_valid = 1'b0; n_valid = 1'b0;
    m_data = '0; l_data = '0; n_data = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({m_so, m_sv, m_ws, m_wd, m_busy, m_ready} !== 6'b000001) begin
      errors++; $display("FAIL reset_msb: got %b want 000001", {m_so, m_sv, m_ws, m_wd, m_busy, m_ready});
    end
    checks++;
    if ({l_so, l_sv, l_ws, l_wd, l_busy, l_ready} !== 6'b100001) begin
      errors++; $display("FAIL reset_lsb: got %b want 100001", {l_so, l_sv, l_ws, l_wd, l_busy, l_ready});
    end
    checks++;
    if ({n_so, n_sv, n_ws, n_wd, n_busy, n_ready} !== 6'b000001) begin
      errors++; $display("FAIL reset_w2: got %b want 000001", {n_so, n_sv, n_ws, n_wd, n_busy, n_ready});
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({m_sv, m_busy, m_ready} !== 3'b001) begin
      errors++; $display("FAIL after_reset: got %b want 001", {m_sv, m_busy, m_ready});
    end
  endtask

  task automatic test_single_msb(input logic [7:0] w, input string name);
    @(negedge clk);
    m_valid = 1'b1; m_data = w;
    checks++;
    if (m_ready !== 1'b1) begin errors++; $display("FAIL %s ready: got %b want 1", name, m_ready); end
    @(negedge clk);
    m_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if ({m_so, m_sv, m_ws, m_wd} !== {w[7-i], 1'b1, i == 0, i == 7}) begin
        errors++;
        $display("FAIL %s bit %0d: got %b want %b", name, i, {m_so, m_sv, m_ws, m_wd},
                 {w[7-i], 1'b1, i == 0, i == 7});
      end
      @(negedge clk);
    end
    checks++;
    if ({m_so, m_sv, m_busy} !== 3'b000) begin
      errors++; $display("FAIL %s idle: got %b want 000", name, {m_so, m_sv, m_busy});
    end
  endtask

  task automatic test_single_lsb;
    logic [7:0] w = 8'hB4;
    @(negedge clk);
    l_valid = 1'b1; l_data = w;
    @(negedge clk);
    l_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if ({l_so, l_sv, l_ws, l_wd} !== {w[i], 1'b1, i == 0, i == 7}) begin
        errors++;
        $display("FAIL single_lsb bit %0d: got %b want %b", i, {l_so, l_sv, l_ws, l_wd},
                 {w[i], 1'b1, i == 0, i == 7});
      end
      @(negedge clk);
    end
    checks++;
    if ({l_so, l_sv, l_busy} !== 3'b100) begin
      errors++; $display("FAIL single_lsb idle: got %b want 100", {l_so, l_sv, l_busy});
    end
  endtask

  // Three words offered with in_valid held: gapless 24-bit stream, third word held off by backpressure
  task automatic test_stream(input logic [7:0] w0, input logic [7:0] w1, input logic [7:0] w2,
                             input string name);
    logic [7:0]  w [3];
    logic [23:0] bits;
    logic        xfer;
    logic        exp_ready;
    int          idx = 0;
    w[0] = w0; w[1] = w1; w[2] = w2;
    bits = {w0, w1, w2};
    @(negedge clk);
    m_valid = 1'b1; m_data = w[0];
    xfer = m_ready;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (xfer) idx++;
      m_valid = (idx < 3);
      if (idx < 3) m_data = w[idx];
      if (c < 24) begin
        exp_ready = (c % 8 == 0) || (c >= 16);
        checks++;
        if ({m_so, m_sv, m_ws, m_wd, m_busy, m_ready} !==
            {bits[23-c], 1'b1, c % 8 == 0, c % 8 == 7, 1'b1, exp_ready}) begin
          errors++;
          $display("FAIL %s cyc %0d: got %b want %b", name, c, {m_so, m_sv, m_ws, m_wd, m_busy, m_ready},
                   {bits[23-c], 1'b1, c % 8 == 0, c % 8 == 7, 1'b1, exp_ready});
        end
      end else begin
        checks++;
        if ({m_so, m_sv, m_ws, m_wd, m_busy, m_ready} !== 6'b000001) begin
          errors++;
          $display("FAIL %s end: got %b want 000001", name, {m_so, m_sv, m_ws, m_wd, m_busy, m_ready});
        end
      end
      xfer = m_valid && m_ready;
    end
    checks++;
    if (idx !== 3) begin errors++; $display("FAIL %s accepts: got %0d want 3", name, idx); end
  endtask

  task automatic test_reset_midword;
    logic [7:0] w1 = 8'($urandom);
    logic [7:0] w2 = 8'($urandom);
    @(negedge clk);
    m_valid = 1'b1; m_data = w1;
    @(negedge clk);
    m_data = w2;
    @(negedge clk);
    m_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({m_sv, m_busy, m_ready} !== 3'b110) begin
      errors++; $display("FAIL midword_pre: got %b want 110", {m_sv, m_busy, m_ready});
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({m_so, m_sv, m_ws, m_wd, m_busy, m_ready} !== 6'b000001) begin
      errors++; $display("FAIL midword_rst: got %b want 000001", {m_so, m_sv, m_ws, m_wd, m_busy, m_ready});
    end
    m_valid = 1'b1; m_data = 8'($urandom);
    @(posedge clk);
    #1;
    checks++;
    if ({m_so, m_sv, m_ws, m_wd, m_busy, m_ready} !== 6'b000001) begin
      errors++; $display("FAIL midword_hold: got %b want 000001", {m_so, m_sv, m_ws, m_wd, m_busy, m_ready});
    end
    @(negedge clk);
    reset = 1'b0; m_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if ({m_sv, m_busy, m_ready} !== 3'b001) begin
        errors++; $display("FAIL midword_after cyc %0d: got %b want 001", i, {m_sv, m_busy, m_ready});
      end
    end
    test_single_msb(8'($urandom), "midword_new");
  endtask

  task automatic test_width2;
    logic [1:0] w [2];
    logic [3:0] bits = 4'b1001;
    logic       xfer;
    int         idx = 0;
    w[0] = 2'b10; w[1] = 2'b01;
    @(negedge clk);
    n_valid = 1'b1; n_data = w[0];
    xfer = n_ready;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (xfer) idx++;
      n_valid = (idx < 2);
      if (idx < 2) n_data = w[idx];
      checks++;
      if (c < 4) begin
        if ({n_so, n_sv, n_ws, n_wd} !== {bits[3-c], 1'b1, c % 2 == 0, c % 2 == 1}) begin
          errors++;
          $display("FAIL width2 cyc %0d: got %b want %b", c, {n_so, n_sv, n_ws, n_wd},
                   {bits[3-c], 1'b1, c % 2 == 0, c % 2 == 1});
        end
      end else if ({n_so, n_sv, n_busy} !== 3'b000) begin
        errors++; $display("FAIL width2 end: got %b want 000", {n_so, n_sv, n_busy});
      end
      xfer = n_valid && n_ready;
    end
  endtask

  // Random valid/data against a scoreboard of accepted words
  task automatic test_random;
    logic [7:0] sbq[$];
    logic [7:0] asm = '0;
    logic [7:0] exp_w;
    logic       xfer = 1'b0;
    bit         done = 1'b0;
    int accepted = 0, started = 0, finished = 0, sent = 0, nbits = 0, waiting;
    m_valid = 1'b0;
    for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
      @(negedge clk);
      if (xfer) begin sbq.push_back(m_data); accepted++; end
      if (m_sv && m_ws) started++;
      waiting = accepted - started;
      checks++;
      if ({m_ready, m_busy} !== {waiting == 0, m_sv || waiting != 0}) begin
        errors++;
        $display("FAIL random_flags cyc %0d: got %b want %b", cyc, {m_ready, m_busy},
                 {waiting == 0, m_sv || waiting != 0});
      end
      checks++;
      if (waiting < 0 || waiting > 1 || (!m_sv && waiting != 0)) begin
        errors++; $display("FAIL random_gap cyc %0d: got waiting %0d sv %b want waiting 0..1, no idle gap", cyc, waiting, m_sv);
      end
      if (m_sv) begin
        if (m_ws) nbits = 0;
        asm = {asm[6:0], m_so};
        nbits++;
        checks++;
        if (m_wd !== (nbits == 8)) begin
          errors++; $display("FAIL random_done cyc %0d: got %b want %b", cyc, m_wd, nbits == 8);
        end
        if (m_wd) begin
          checks++;
          if (sbq.size() == 0) begin
            errors++; $display("FAIL random_extra cyc %0d: got word %h want none", cyc, asm);
          end else begin
            exp_w = sbq.pop_front();
            if (asm !== exp_w) begin
              errors++; $display("FAIL random_data cyc %0d: got %h want %h", cyc, asm, exp_w);
            end
          end
          finished++;
        end
      end else begin
        checks++;
        if (m_so !== 1'b0) begin errors++; $display("FAIL random_idle cyc %0d: got %b want 0", cyc, m_so); end
      end
      if (!m_valid || xfer) begin
        if (sent < 40 && $urandom_range(0, 3) != 0) begin
          m_valid = 1'b1; m_data = 8'($urandom); sent++;
        end else begin
          m_valid = 1'b0;
        end
      end
      xfer = m_valid && m_ready;
      done = (sent == 40) && !m_valid && !xfer && (finished == 40) && !m_sv;
    end
    checks++;
    if (!done) begin
      errors++; $display("FAIL random_timeout: got %0d words done want 40", finished);
    end
  endtask

  initial begin
    test_reset();
    test_single_msb(8'hB4, "single_msb");
    test_single_lsb();
    test_stream(8'hFF, 8'h00, 8'hA5, "stream");
    test_stream(8'($urandom), 8'($urandom), 8'($urandom), "backpressure");
    test_reset_midword();
    test_width2();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
